// File: rtl/cache_line_mem_ctrl_pkg.sv
// Shared types for the cache miss/refill controller.
// Line, word and address widths plus the controller state encoding.
package cache_mem_pkg;

    localparam int LINE_WIDTH      = 128;
    localparam int WORD_WIDTH      = 32;
    localparam int WORDS_PER_LINE  = 4;
    localparam int WORD_SEL_BITS   = 2;
    localparam int ADDR_WIDTH      = 10;
    localparam int LINE_ADDR_WIDTH = ADDR_WIDTH - WORD_SEL_BITS;

    typedef enum logic [2:0] {
        IDLE,
        WB_WORD,
        WB_GAP,
        RD_LINE,
        RD_GAP,
        DONE
    } state_t;

    typedef logic [LINE_ADDR_WIDTH-1:0] line_addr_t;
    typedef logic [WORD_WIDTH-1:0]      word_t;
    typedef logic [LINE_WIDTH-1:0]      line_t;
    typedef logic [WORD_SEL_BITS-1:0]   word_idx_t;
    typedef logic [ADDR_WIDTH-1:0]      mem_addr_t;

    function automatic mem_addr_t word_addr(line_addr_t line, word_idx_t idx);
        return {line, idx};
    endfunction

endpackage

// File: rtl/cache_line_mem_ctrl_if.sv
// Cache-side request/fill bundle and memory-side bus bundle.
// master drives the request (cache) or the bus (controller).
interface cache_req_if;
    import cache_mem_pkg::*;

    logic       req_valid;
    logic       req_ready;
    logic       req_wb;
    line_addr_t req_fill_addr;
    line_addr_t req_victim_addr;
    line_t      req_victim_data;
    logic       fill_valid;
    line_t      fill_data;
    line_addr_t fill_addr;
    logic       err;

    modport master (
        output req_valid, req_wb, req_fill_addr,
        output req_victim_addr, req_victim_data,
        input  req_ready, fill_valid, fill_data, fill_addr, err
    );

    modport slave (
        input  req_valid, req_wb, req_fill_addr,
        input  req_victim_addr, req_victim_data,
        output req_ready, fill_valid, fill_data, fill_addr, err
    );
endinterface

interface mem_bus_if;
    import cache_mem_pkg::*;

    logic      mem_rd;
    logic      mem_wr;
    mem_addr_t mem_addr;
    word_t     mem_wdata;
    line_t     mem_rdata;
    logic      mem_data_ready;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_data_ready
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_data_ready
    );
endinterface

// File: rtl/cache_line_mem_ctrl_timer.sv
// Per-access watchdog: clearable, loadable cycle counter.
// expired flags the enabled cycle whose increment reaches LIMIT.
module mem_access_timer #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic             expired
);
    logic [WIDTH-1:0] count;

    // count cycles spent waiting on the memory
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expired = enable && (count == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/cache_line_mem_ctrl.sv
// Miss/refill controller: optional 4-word victim writeback, then
// one bulk line read; returns the line or an error on timeout.
module cache_line_mem_ctrl
    import cache_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_BITS        = 7
) (
    input logic        clock,
    input logic        reset,
    cache_req_if.slave req,
    mem_bus_if.master  mem
);
    state_t     state, nxt_state;
    logic       ready_q, nxt_ready;
    logic       rd_q, nxt_rd;
    logic       wr_q, nxt_wr;
    logic       fv_q, nxt_fv;
    logic       err_q, nxt_err;
    mem_addr_t  addr_q, nxt_addr;
    word_t      wdata_q, nxt_wdata;
    line_t      fdata_q, nxt_fdata;
    line_addr_t faddr_q, nxt_faddr;
    line_addr_t vaddr_q, nxt_vaddr;
    line_t      vdata_q, nxt_vdata;
    word_idx_t  idx_q, nxt_idx;
    logic       t_clear, t_en, t_exp;

    mem_access_timer #(
        .WIDTH (TO_BITS),
        .LIMIT (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (t_clear),
        .load     (1'b0),
        .load_val ('0),
        .enable   (t_en),
        .expired  (t_exp)
    );

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt_state;
    end

    // next state and next values of every registered output
    always_comb begin
        nxt_state = state;
        nxt_ready = 1'b0;
        nxt_rd    = 1'b0;
        nxt_wr    = 1'b0;
        nxt_fv    = 1'b0;
        nxt_err   = 1'b0;
        nxt_addr  = addr_q;
        nxt_wdata = wdata_q;
        nxt_fdata = fdata_q;
        nxt_faddr = faddr_q;
        nxt_vaddr = vaddr_q;
        nxt_vdata = vdata_q;
        nxt_idx   = idx_q;
        t_clear   = 1'b0;
        t_en      = 1'b0;
        unique case (state)
            IDLE: begin
                nxt_ready = 1'b1;
                if (req.req_valid) begin
                    nxt_ready = 1'b0;
                    nxt_faddr = req.req_fill_addr;
                    nxt_vaddr = req.req_victim_addr;
                    nxt_vdata = req.req_victim_data;
                    t_clear   = 1'b1;
                    if (req.req_wb) begin
                        nxt_state = WB_WORD;
                        nxt_idx   = '0;
                        nxt_wr    = 1'b1;
                        nxt_addr  = word_addr(req.req_victim_addr, '0);
                        nxt_wdata = req.req_victim_data[WORD_WIDTH-1:0];
                    end else begin
                        nxt_state = RD_LINE;
                        nxt_rd    = 1'b1;
                        nxt_addr  = word_addr(req.req_fill_addr, '0);
                    end
                end
            end
            WB_WORD: begin
                t_en = !mem.mem_data_ready;
                if (mem.mem_data_ready) begin
                    nxt_state = WB_GAP;
                end else if (t_exp) begin
                    nxt_state = DONE;
                    nxt_err   = 1'b1;
                end else begin
                    nxt_wr = 1'b1;
                end
            end
            WB_GAP: begin
                t_clear = 1'b1;
                if (idx_q == word_idx_t'(WORDS_PER_LINE - 1)) begin
                    nxt_state = RD_LINE;
                    nxt_rd    = 1'b1;
                    nxt_addr  = word_addr(faddr_q, '0);
                end else begin
                    nxt_state = WB_WORD;
                    nxt_idx   = idx_q + 2'd1;
                    nxt_wr    = 1'b1;
                    nxt_addr  = word_addr(vaddr_q, nxt_idx);
                    nxt_wdata = vdata_q[nxt_idx*WORD_WIDTH +: WORD_WIDTH];
                end
            end
            RD_LINE: begin
                t_en = !mem.mem_data_ready;
                if (mem.mem_data_ready) begin
                    nxt_state = RD_GAP;
                    nxt_fv    = 1'b1;
                    nxt_fdata = mem.mem_rdata;
                end else if (t_exp) begin
                    nxt_state = DONE;
                    nxt_err   = 1'b1;
                end else begin
                    nxt_rd = 1'b1;
                end
            end
            RD_GAP: begin
                nxt_state = DONE;
            end
            DONE: begin
                nxt_state = IDLE;
                nxt_ready = 1'b1;
            end
            default: begin
                nxt_state = IDLE;
                nxt_ready = 1'b1;
            end
        endcase
    end

    // registered outputs and latched request
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fdata_q <= '0;
            faddr_q <= '0;
            vaddr_q <= '0;
            vdata_q <= '0;
            idx_q   <= '0;
        end else begin
            ready_q <= nxt_ready;
            rd_q    <= nxt_rd;
            wr_q    <= nxt_wr;
            fv_q    <= nxt_fv;
            err_q   <= nxt_err;
            addr_q  <= nxt_addr;
            wdata_q <= nxt_wdata;
            fdata_q <= nxt_fdata;
            faddr_q <= nxt_faddr;
            vaddr_q <= nxt_vaddr;
            vdata_q <= nxt_vdata;
            idx_q   <= nxt_idx;
        end
    end

    assign req.req_ready  = ready_q;
    assign req.fill_valid = fv_q;
    assign req.fill_data  = fdata_q;
    assign req.fill_addr  = faddr_q;
    assign req.err        = err_q;
    assign mem.mem_rd     = rd_q;
    assign mem.mem_wr     = wr_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_cache_line_mem_ctrl.sv
// Bench for cache_line_mem_ctrl: memory responder, transaction
// model with a per-cycle compare process, and directed scenarios.
module tb_cache_line_mem_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;

    cache_req_if creq();
    mem_bus_if   mbus();

    cache_line_mem_ctrl #(
        .TIMEOUT_CYCLES (64),
        .TO_BITS        (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (creq),
        .mem   (mbus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        bit           is_err;
        logic [7:0]   addr;
        logic [127:0] data;
    } out_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_seen  = 0;
    int lat      = 1;
    bit stall    = 1'b0;

    logic [31:0] mem_arr   [1024];
    logic [31:0] model_mem [1024];

    acc_t        exp_acc[$];
    out_t        exp_out[$];
    logic [9:0]  obs_wr_addr[$];
    logic [31:0] obs_wr_data[$];
    int          fill_cycs[$];
    logic [7:0]  obs_fill_addr[$];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // model: what the memory must see and what the cache must get back
    task automatic model_req(input bit wb, input logic [7:0] fa,
                             input logic [7:0] va, input logic [127:0] vd);
        acc_t a;
        out_t o;
        if (wb) begin
            for (int k = 0; k < 4; k++) begin
                a.is_wr = 1'b1;
                a.addr  = {va, 2'(k)};
                a.data  = vd[32*k +: 32];
                exp_acc.push_back(a);
                model_mem[{va, 2'(k)}] = vd[32*k +: 32];
            end
        end
        if (stall) begin
            o.is_err = 1'b1;
            o.addr   = fa;
            o.data   = '0;
            exp_out.push_back(o);
        end else begin
            a.is_wr = 1'b0;
            a.addr  = {fa, 2'b00};
            a.data  = '0;
            exp_acc.push_back(a);
            o.is_err = 1'b0;
            o.addr   = fa;
            o.data   = {model_mem[{fa, 2'd3}], model_mem[{fa, 2'd2}],
                        model_mem[{fa, 2'd1}], model_mem[{fa, 2'd0}]};
            exp_out.push_back(o);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!creq.req_ready && n < 200) begin
            step();
            n++;
        end
        if (!creq.req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: req_ready stuck at 0");
        end
    endtask

    task automatic issue(input bit wb, input logic [7:0] fa,
                         input logic [7:0] va, input logic [127:0] vd);
        creq.req_wb          = wb;
        creq.req_fill_addr   = fa;
        creq.req_victim_addr = va;
        creq.req_victim_data = vd;
        creq.req_valid       = 1'b1;
        wait_ready();
        model_req(wb, fa, va, vd);
        step();
        creq.req_valid = 1'b0;
    endtask

    task automatic wait_fill(output int k);
        k = 0;
        while (!creq.fill_valid && k < 200) begin
            step();
            k++;
        end
    endtask

    // memory: answers each access lat cycles after it starts
    initial begin : memory
        int cnt;
        logic [9:0] a;
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            mem_arr[i]   = 32'hC0DE0000 | 32'(i);
            model_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        mbus.mem_data_ready = 1'b0;
        mbus.mem_rdata      = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset || mbus.mem_data_ready) begin
                mbus.mem_data_ready = 1'b0;
                cnt = 0;
            end else if (!stall && (mbus.mem_rd || mbus.mem_wr)) begin
                if (cnt == lat - 1) begin
                    mbus.mem_data_ready = 1'b1;
                    if (mbus.mem_wr) begin
                        mem_arr[mbus.mem_addr] = mbus.mem_wdata;
                    end else begin
                        a = {mbus.mem_addr[9:2], 2'b00};
                        mbus.mem_rdata = {mem_arr[a + 10'd3], mem_arr[a + 10'd2],
                                          mem_arr[a + 10'd1], mem_arr[a]};
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    // compare process: DUT outputs against the model every cycle
    always @(negedge clock) begin : compare
        acc_t a;
        out_t o;
        if (reset) begin
            check("rd_wr_excl", 128'(mbus.mem_rd & mbus.mem_wr), 128'(0));
            check("fill_err_excl", 128'(creq.fill_valid & creq.err), 128'(0));
            if (mbus.mem_data_ready && (mbus.mem_rd || mbus.mem_wr)) begin
                if (exp_acc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_access: addr %0h", mbus.mem_addr);
                end else begin
                    a = exp_acc.pop_front();
                    check("acc_is_wr", 128'(mbus.mem_wr), 128'(a.is_wr));
                    check("acc_addr", 128'(mbus.mem_addr), 128'(a.addr));
                    if (a.is_wr) begin
                        check("acc_wdata", 128'(mbus.mem_wdata), 128'(a.data));
                    end
                end
                if (mbus.mem_wr) begin
                    wr_seen++;
                    obs_wr_addr.push_back(mbus.mem_addr);
                    obs_wr_data.push_back(mbus.mem_wdata);
                end
            end
            if (creq.fill_valid || creq.err) begin
                if (exp_out.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_outcome: fill %0b err %0b",
                             creq.fill_valid, creq.err);
                end else begin
                    o = exp_out.pop_front();
                    check("out_is_err", 128'(creq.err), 128'(o.is_err));
                    if (creq.fill_valid) begin
                        check("fill_addr", 128'(creq.fill_addr), 128'(o.addr));
                        check("fill_data", creq.fill_data, o.data);
                    end
                end
                if (creq.fill_valid) begin
                    fill_cycs.push_back(cyc);
                    obs_fill_addr.push_back(creq.fill_addr);
                end
            end
        end
    end

    initial begin : stim
        int k;
        int base;
        logic [7:0] trace;
        creq.req_valid       = 1'b0;
        creq.req_wb          = 1'b0;
        creq.req_fill_addr   = '0;
        creq.req_victim_addr = '0;
        creq.req_victim_data = '0;

        // reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", 128'(creq.req_ready), 128'(1));
        check("rst_rd", 128'(mbus.mem_rd), 128'(0));
        check("rst_wr", 128'(mbus.mem_wr), 128'(0));
        check("rst_fill_valid", 128'(creq.fill_valid), 128'(0));
        check("rst_err", 128'(creq.err), 128'(0));
        check("rst_addr", 128'(mbus.mem_addr), 128'(0));
        check("rst_wdata", 128'(mbus.mem_wdata), 128'(0));
        check("rst_fill_data", creq.fill_data, 128'(0));
        check("rst_fill_addr", 128'(creq.fill_addr), 128'(0));
        reset = 1'b1;
        step();

        // clean miss, memory answers 3 cycles after mem_rd
        lat = 3;
        issue(1'b0, 8'h2A, 8'h00, '0);
        check("clean_rd", 128'(mbus.mem_rd), 128'(1));
        check("clean_wr", 128'(mbus.mem_wr), 128'(0));
        check("clean_addr", 128'(mbus.mem_addr), 128'(10'h0A8));
        wait_fill(k);
        check("clean_latency", 128'(k), 128'(3));
        check("clean_fill_addr", 128'(creq.fill_addr), 128'(8'h2A));
        check("clean_fill_data", creq.fill_data,
              128'hC0DE00AB_C0DE00AA_C0DE00A9_C0DE00A8);
        step();
        check("clean_pulse", 128'(creq.fill_valid), 128'(0));
        check("clean_done_ready", 128'(creq.req_ready), 128'(0));
        step();
        check("clean_idle_ready", 128'(creq.req_ready), 128'(1));

        // dirty miss with a rejected request pulse during writeback
        lat = 1;
        base = obs_wr_addr.size();
        issue(1'b1, 8'h05, 8'h11,
              128'h44444444_33333333_22222222_11111111);
        trace = '0;
        for (int i = 0; i < 8; i++) begin
            trace[i] = mbus.mem_wr;
            if (i == 3) begin
                creq.req_fill_addr = 8'h07;
                creq.req_valid     = 1'b1;
            end
            if (i == 4) begin
                check("busy_ready", 128'(creq.req_ready), 128'(0));
                creq.req_valid = 1'b0;
            end
            step();
        end
        check("wb_wr_trace", 128'(trace), 128'(8'h55));
        check("wb_rd", 128'(mbus.mem_rd), 128'(1));
        check("wb_rd_addr", 128'(mbus.mem_addr), 128'(10'h014));
        step();
        check("wb_fill_valid", 128'(creq.fill_valid), 128'(1));
        check("wb_fill_addr", 128'(creq.fill_addr), 128'(8'h05));
        check("wb_fill_data", creq.fill_data,
              128'hC0DE0017_C0DE0016_C0DE0015_C0DE0014);
        check("wb_count", 128'(obs_wr_addr.size() - base), 128'(4));
        if (obs_wr_addr.size() >= base + 4) begin
            check("wb_first_addr", 128'(obs_wr_addr[base]), 128'(10'h044));
            check("wb_first_data", 128'(obs_wr_data[base]), 128'(32'h11111111));
            check("wb_last_addr", 128'(obs_wr_addr[base+3]), 128'(10'h047));
            check("wb_last_data", 128'(obs_wr_data[base+3]), 128'(32'h44444444));
        end
        repeat (4) step();

        // timeout: memory never answers the read
        stall = 1'b1;
        issue(1'b0, 8'h33, 8'h00, '0);
        check("to_rd", 128'(mbus.mem_rd), 128'(1));
        k = 0;
        while (!creq.err && k < 200) begin
            step();
            k++;
        end
        check("to_latency", 128'(k), 128'(63));
        check("to_rd_dropped", 128'(mbus.mem_rd), 128'(0));
        check("to_no_fill", 128'(creq.fill_valid), 128'(0));
        step();
        check("to_err_pulse", 128'(creq.err), 128'(0));
        check("to_ready", 128'(creq.req_ready), 128'(1));
        stall = 1'b0;

        // reset in the middle of word 2 of a writeback
        lat = 3;
        base = wr_seen;
        issue(1'b1, 8'h09, 8'h22,
              128'h88887777_66665555_44443333_22221111);
        k = 0;
        while (!(wr_seen == base + 2 && mbus.mem_wr) && k < 100) begin
            step();
            k++;
        end
        check("rstwb_word2_reached", 128'(mbus.mem_wr), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check("rstwb_wr", 128'(mbus.mem_wr), 128'(0));
        check("rstwb_ready", 128'(creq.req_ready), 128'(1));
        check("rstwb_addr", 128'(mbus.mem_addr), 128'(0));
        check("rstwb_wdata", 128'(mbus.mem_wdata), 128'(0));
        check("rstwb_fill_addr", 128'(creq.fill_addr), 128'(0));
        check("rstwb_pending_acc", 128'(exp_acc.size()), 128'(3));
        check("rstwb_pending_out", 128'(exp_out.size()), 128'(1));
        exp_acc.delete();
        exp_out.delete();
        @(posedge clock);
        #1;
        reset = 1'b1;
        lat = 2;
        issue(1'b0, 8'h3C, 8'h00, '0);
        wait_fill(k);
        check("post_rst_fill", 128'(creq.fill_valid), 128'(1));
        check("post_rst_data", creq.fill_data,
              128'hC0DE00F3_C0DE00F2_C0DE00F1_C0DE00F0);
        repeat (3) step();

        // back-to-back with req_valid held high
        lat = 2;
        base = fill_cycs.size();
        creq.req_wb        = 1'b0;
        creq.req_fill_addr = 8'h01;
        creq.req_valid     = 1'b1;
        wait_ready();
        model_req(1'b0, 8'h01, 8'h00, '0);
        step();
        creq.req_fill_addr = 8'h02;
        wait_ready();
        model_req(1'b0, 8'h02, 8'h00, '0);
        step();
        creq.req_valid = 1'b0;
        k = 0;
        while (fill_cycs.size() < base + 2 && k < 200) begin
            step();
            k++;
        end
        check("b2b_fills", 128'(fill_cycs.size() - base), 128'(2));
        if (fill_cycs.size() >= base + 2) begin
            check("b2b_spacing", 128'(fill_cycs[base+1] - fill_cycs[base]),
                  128'(5));
            check("b2b_first", 128'(obs_fill_addr[base]), 128'(8'h01));
            check("b2b_second", 128'(obs_fill_addr[base+1]), 128'(8'h02));
        end

        repeat (10) step();
        check("acc_queue_empty", 128'(exp_acc.size()), 128'(0));
        check("out_queue_empty", 128'(exp_out.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_mem_ctrl.md
Name: cache_line_mem_ctrl

Overview:
Miss/refill controller between the 4-way set-associative cache and Main_Memory_System.
- Accepts one miss request at a time from the cache.
- For a dirty victim, writes the victim line back as four sequential 32-bit word writes, then reads the requested line as one 128-bit bulk read.
- Returns the filled line to the cache.
- Owns all memory-side handshaking, including a watchdog timeout.

Parameters:
- LINE_WIDTH, 128, cache line / memory bulk-read width
- WORD_WIDTH, 32, memory write word width
- WORDS_PER_LINE, 4, words per line (= number of memory banks)
- WORD_SEL_BITS, 2, log2(WORDS_PER_LINE); low address bits that select the bank
- ADDR_WIDTH, 10, memory word address width
- LINE_ADDR_WIDTH, 8, ADDR_WIDTH - WORD_SEL_BITS
- TIMEOUT_CYCLES, 64, maximum cycles to wait for mem_data_ready per access
- TO_BITS, 7, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  cache miss request
- req_ready  out  1  controller idle, can accept a request
- req_wb  in  1  victim is dirty; write back before the fill
- req_fill_addr  in  LINE_ADDR_WIDTH  line address to fetch
- req_victim_addr  in  LINE_ADDR_WIDTH  line address of the victim
- req_victim_data  in  LINE_WIDTH  victim line; word k at bits [32k+31:32k]
- fill_valid  out  1  one-cycle pulse: fill_data is valid
- fill_data  out  LINE_WIDTH  fetched line
- fill_addr  out  LINE_ADDR_WIDTH  echo of the accepted req_fill_addr
- err  out  1  one-cycle pulse: access timed out, request aborted
- mem_rd  out  1  to Main_Memory_System rd
- mem_wr  out  1  to Main_Memory_System wr
- mem_addr  out  ADDR_WIDTH  {line_addr, word_idx}
- mem_wdata  out  WORD_WIDTH  write word
- mem_rdata  in  LINE_WIDTH  bulk read data; bank k at bits [32k+31:32k]
- mem_data_ready  in  1  memory access complete

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous, any state, including mid-writeback or mid-read):
  - state=IDLE; req_ready=1.
  - mem_rd, mem_wr, fill_valid, err = 0.
  - mem_addr, mem_wdata, fill_data, fill_addr, word_idx, timeout counter = 0.
  - A partial writeback is abandoned; nothing is retried.
- States: IDLE, WB_WORD, WB_GAP, RD_LINE, RD_GAP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a clock edge: latch all req_* inputs; req_ready goes to 0.
  - If req_wb=1: next state WB_WORD with word_idx=0. Otherwise next state RD_LINE.
- WB_WORD:
  - mem_wr=1, mem_addr={victim_addr, word_idx}, mem_wdata=victim word[word_idx].
  - Hold these until the edge where mem_data_ready=1; then drop mem_wr and go to WB_GAP.
- WB_GAP:
  - One cycle with mem_rd=mem_wr=0, so the memory's data_ready can deassert.
  - If word_idx=WORDS_PER_LINE-1, go to RD_LINE. Otherwise word_idx+1 (2-bit, no wrap beyond 3) and back to WB_WORD.
- RD_LINE:
  - mem_rd=1, mem_addr={fill_addr, 2'b00}.
  - On the edge with mem_data_ready=1: capture mem_rdata into fill_data, drop mem_rd, go to RD_GAP.
- RD_GAP: one idle cycle; fill_valid=1 in this cycle, with fill_addr = latched address. Then go to DONE.
- DONE: fill_valid=0; req_ready=1 next cycle (state IDLE).
  - Minimum spacing between two accepted requests is therefore 3 cycles plus memory latency.
- Clean-miss latency: request accepted at edge 0. mem_rd=1 from cycle 1. If mem_data_ready is seen at edge N, fill_valid is high in cycle N+1.
- Timeout:
  - The counter clears on entry to WB_WORD or RD_LINE and increments each cycle mem_data_ready=0.
  - On reaching TIMEOUT_CYCLES-1 without ready: drop mem_rd/mem_wr, pulse err=1 for one cycle, no fill_valid, return to IDLE (req_ready=1 the following cycle).
- mem_data_ready is ignored outside WB_WORD and RD_LINE.
- req_valid while req_ready=0 is ignored and not queued; the cache holds req_valid until accepted.
- mem_rd and mem_wr are never high in the same cycle.
- fill_valid and err are never high in the same cycle.

Decomposition:
- Shared package cache_mem_pkg:
  - state enum (IDLE, WB_WORD, WB_GAP, RD_LINE, RD_GAP, DONE).
  - LINE_WIDTH, WORD_WIDTH, WORDS_PER_LINE, WORD_SEL_BITS, ADDR_WIDTH, LINE_ADDR_WIDTH.
  - line_addr_t, word_t, and line_t typedefs.
- One sub-module, mem_access_timer: loadable cycle counter with clear, enable and an expired flag.
- Word selection from the latched victim line stays inline (indexed part-select).

Test Plan:
- Clean miss: req_valid=1, req_wb=0, fill_addr=0x2A; memory ready 3 cycles after mem_rd -> mem_addr=0x0A8, mem_wr never asserted, fill_valid one cycle with fill_data=mem_rdata, fill_addr=0x2A.
- Dirty miss: req_wb=1, victim_addr=0x11, victim_data=0x44444444_33333333_22222222_11111111, fill_addr=0x05 -> four writes at mem_addr 0x044..0x047 with data 0x11111111..0x44444444, each followed by one idle cycle, then read at 0x014 and fill_valid.
- Busy rejection: second req_valid pulse (fill_addr=0x07) during writeback -> ignored, req_ready stays 0, only fill_addr=0x05 returned.
- Timeout: mem_data_ready held 0 in RD_LINE -> err pulses exactly once, TIMEOUT_CYCLES-1 cycles after mem_rd rises, no fill_valid, req_ready=1 next cycle.
- Reset mid-writeback: assert reset=0 during word 2 of a writeback -> mem_wr=0 immediately (asynchronous), all outputs at reset values. After release, a clean miss completes normally.
- Back-to-back: req_valid held high for two requests (0x01 then 0x02) -> two fills in order, at least 3 cycles plus memory latency apart, no overlapping mem_rd.
